// File: rtl/fetch_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_exec_sequencer
// Brief    : Multi-cycle fetch/decode/execute control FSM for LB, ADD and SB.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_exec_sequencer #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [23:0] pc_in,
    output logic [1:0]  pc_control,
    output logic        flash_re,
    output logic        flash_we,
    output logic [23:0] flash_addr,
    output logic [7:0]  flash_wdata,
    input  logic [7:0]  flash_rdata,
    output logic [31:0] ir,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic [7:0]  rd1,
    input  logic [7:0]  rd2,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_result,
    output logic        reg_we,
    output logic [7:0]  reg_wd,
    output logic        busy,
    output logic        instr_done,
    output logic        illegal
);

    localparam logic [2:0] c_LAST      = 3'(READ_LATENCY);
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_ALU    = 7'b0110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EX_LB     = 4'd3,
        S_EX_ADD    = 4'd4,
        S_EX_ADD_WB = 4'd5,
        S_EX_SB     = 4'd6,
        S_DONE      = 4'd7,
        S_TRAP      = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_wait;
    logic [1:0]  r_idx;
    logic [31:0] r_ir;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic        r_illegal;

    logic        w_wait_last;
    logic        w_dec_lb;
    logic        w_dec_add;
    logic        w_dec_sb;
    logic        w_unused;

    assign w_wait_last = (r_wait == c_LAST);
    assign w_dec_lb    = (r_ir[6:0] == c_OP_LOAD)  && (r_ir[14:12] == 3'b000);
    assign w_dec_add   = (r_ir[6:0] == c_OP_ALU)   && (r_ir[14:12] == 3'b000)
                         && (r_ir[31:25] == 7'b0000000);
    assign w_dec_sb    = (r_ir[6:0] == c_OP_STORE) && (r_ir[14:12] == 3'b000);
    // Flash space is 24 bits wide; the top immediate byte is never an address.
    assign w_unused    = &{1'b0, imm[31:24]};

    assign ir      = r_ir;
    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign illegal = r_illegal;
    assign busy    = (r_state != S_IDLE) && (r_state != S_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wait    <= 3'd0;
            r_idx     <= 2'd0;
            r_ir      <= 32'd0;
            r_alu_a   <= 8'd0;
            r_alu_b   <= 8'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_FETCH) || (r_state == S_EX_LB)) begin
                r_wait <= w_wait_last ? 3'd0 : r_wait + 3'd1;
            end else begin
                r_wait <= 3'd0;
            end

            if (r_state == S_IDLE) begin
                r_idx <= 2'd0;
            end else if ((r_state == S_FETCH) && w_wait_last) begin
                r_ir[{r_idx, 3'b000} +: 8] <= flash_rdata;
                r_idx                      <= r_idx + 2'd1;
            end

            if (r_state == S_EX_ADD) begin
                r_alu_a <= rd1;
                r_alu_b <= rd2;
            end

            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        pc_control  = 2'b00;
        flash_re    = 1'b0;
        flash_we    = 1'b0;
        flash_addr  = 24'd0;
        flash_wdata = 8'd0;
        reg_we      = 1'b0;
        reg_wd      = 8'd0;
        instr_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                flash_re   = 1'b1;
                flash_addr = pc_in;
                // The byte is captured and the PC bumped in the same cycle.
                if (w_wait_last) begin
                    pc_control = 2'b01;
                    if (r_idx == 2'd3) w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec_lb)       w_next = S_EX_LB;
                else if (w_dec_add) w_next = S_EX_ADD;
                else if (w_dec_sb)  w_next = S_EX_SB;
                else                w_next = S_TRAP;
            end
            S_EX_LB: begin
                flash_re   = 1'b1;
                flash_addr = imm[23:0];
                if (w_wait_last) begin
                    reg_wd = flash_rdata;
                    reg_we = (rd != 5'd0);
                    w_next = S_DONE;
                end
            end
            S_EX_ADD: begin
                w_next = S_EX_ADD_WB;
            end
            S_EX_ADD_WB: begin
                reg_wd = alu_result;
                reg_we = (rd != 5'd0);
                w_next = S_DONE;
            end
            S_EX_SB: begin
                flash_we    = 1'b1;
                flash_addr  = imm[23:0];
                flash_wdata = rd2;
                w_next      = S_DONE;
            end
            S_DONE: begin
                instr_done = 1'b1;
                w_next     = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/fetch_exec_sequencer.md
Name: fetch_exec_sequencer

Overview:
- Multi-cycle control FSM that sequences the existing datapath: program_counter, byte-wide flash, control_unit, alu and register_file.
- Each instruction is fetched as 4 bytes, little-endian, from flash at the current PC, advancing the PC once per byte.
- The assembled IR is presented to control_unit, then the LB, ADD or SB datapath operations are sequenced.
- The block replaces hand-driven fetch/decode/execute stimulus and sits between the top-level run control and the datapath blocks.

Parameters:
- READ_LATENCY, 2, clock cycles from flash_re/flash_addr stable to flash_rdata valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- pc_in  in  24  pc_out of program_counter.
- pc_control  out  2  to program_counter; 00 = hold, 01 = increment.
- flash_re  out  1  flash read enable.
- flash_we  out  1  flash write enable.
- flash_addr  out  24  flash byte address.
- flash_wdata  out  8  flash write data.
- flash_rdata  in  8  flash read data.
- ir  out  32  assembled instruction register; drives control_unit ir/funct3/funct7.
- imm  in  32  control_unit immediate.
- rd  in  5  control_unit destination register index.
- rd1  in  8  register_file read port 1 (rs1).
- rd2  in  8  register_file read port 2 (rs2).
- alu_a  out  8  ALU operand A.
- alu_b  out  8  ALU operand B.
- alu_result  in  8  ALU result.
- reg_we  out  1  register_file write enable.
- reg_wd  out  8  register_file write data.
- busy  out  1  1 in any state except IDLE and TRAP.
- instr_done  out  1  one-cycle pulse per retired instruction.
- illegal  out  1  sticky; set on an unsupported encoding, cleared only by reset.

Behaviour:
- Reset values: all outputs 0, including ir, flash_addr, pc_control and illegal. State = IDLE, byte index = 0, wait counter = 0.
- State set: IDLE, FETCH, DECODE, EX_LB, EX_ADD, EX_ADD_WB, EX_SB, DONE, TRAP.
- IDLE: when run = 1, go to FETCH on the next edge with byte index = 0.
- FETCH:
  - flash_re = 1 and flash_addr = pc_in every cycle.
  - The wait counter counts 0..READ_LATENCY.
  - At count == READ_LATENCY: latch flash_rdata into ir[8*idx+7:8*idx] and drive pc_control = 01 for that cycle only.
  - Then reset the counter and increment idx.
  - After idx 3 is captured, go to DECODE.
  - One byte takes READ_LATENCY+1 cycles; a full fetch takes 4*(READ_LATENCY+1) cycles.
  - The PC advances by 4 per instruction.
- DECODE (1 cycle; flash_re = 0): classify on ir[6:0], ir[14:12], ir[31:25].
  - 0000011 with f3 = 000 → EX_LB.
  - 0110011 with f3 = 000 and f7 = 0000000 → EX_ADD.
  - 0100011 with f3 = 000 → EX_SB.
  - Anything else → TRAP.
- EX_LB (READ_LATENCY+1 cycles):
  - flash_re = 1, flash_addr = imm[23:0].
  - On the last cycle: reg_wd = flash_rdata and reg_we = 1, but only if rd != 0. A write to x0 is suppressed.
  - Then go to DONE.
- EX_ADD (1 cycle): register alu_a <= rd1 and alu_b <= rd2.
- EX_ADD_WB (1 cycle): reg_wd = alu_result, reg_we = (rd != 0). Wrap-around is 8-bit; there is no carry handling.
- EX_SB (1 cycle): flash_we = 1, flash_addr = imm[23:0], flash_wdata = rd2.
- DONE (1 cycle): instr_done = 1. Go to FETCH if run = 1, else to IDLE.
- TRAP:
  - illegal = 1; all enables and pc_control are 0.
  - Held until reset; run is ignored.
  - The PC stays at the address after the offending instruction.
- Enable invariants:
  - flash_re and flash_we are never 1 in the same cycle.
  - reg_we is high for exactly one cycle per LB or ADD.
  - pc_control = 01 only in FETCH capture cycles.
- run deassertion mid-instruction: the instruction completes through DONE, then the block goes to IDLE.
- Reset asserted in any state: next cycle equals the reset values. No partial write may follow; reg_we and flash_we are 0 in the cycle after reset.
- Latency from FETCH entry to the instr_done cycle, inclusive:
  - LB: 5*(READ_LATENCY+1)+2.
  - ADD: 4*(READ_LATENCY+1)+4.
  - SB: 4*(READ_LATENCY+1)+3.
  - With READ_LATENCY = 2 this gives LB 17, ADD 16, SB 15.
- imm and rd are combinational from ir and stable from DECODE onward. rd1/rd2 are valid from EX_* onward.

Test Plan:
- Program at 0x00: 0x02000283, 0x02100303, 0x006283b3, 0x02700123; data flash[0x20] = 0x0A, flash[0x21] = 0x5A; run = 1 → after 4 instr_done pulses:
  - t0 = 0x0A, t1 = 0x5A, t2 = 0x64.
  - flash[0x22] = 0x64.
  - pc_in = 0x000010.
- Fetch timing, READ_LATENCY = 2, first LB → pc_control = 01 pulses on cycles 3, 6, 9 and 12 after FETCH entry; ir = 0x02000283 at DECODE; instr_done on cycle 17.
- ADD overflow: t0 = 0xF0, t1 = 0x20, execute add t2,t0,t1 → t2 = 0x10 with a single reg_we pulse; LB with rd = x0 → no reg_we.
- Unsupported word 0x00000013 (addi) → illegal = 1 on the cycle after DECODE, busy = 0, no further flash_re; reset clears illegal.
- Drop run during fetch of instruction 2 → instruction 2 retires and the block goes to IDLE with pc_in = 0x000008; re-assert run → instruction 3 proceeds.
- Assert reset during EX_LB last cycle-1 → reg_we never pulses; all outputs 0 on the next cycle; state = IDLE.
